// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Two-stage valid/ready pipeline that packs a 32-bit immediate (or a byte
// offset) into a 20-bit instruction immediate field. It also reports whether
// the value is exactly representable in the selected encoding.
//
//   S1: captures in_value/in_mode. The encoding is computed combinationally
//       from the S1 registers.
//   S2: output register that drives out_valid/out_field/out_fits.
//
// Modes: 00 zero-extended 16-bit, 01 sign-extended 16-bit,
//        10 word-aligned branch offset (20 bits of words), 11 illegal.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready depends on out_ready only
//   in_value, in_mode   value to encode and encoding selector
//   out_valid/out_ready result handshake
//   out_field, out_fits packed field and exact-representation flag
//   err_count           saturating count of delivered non-fitting results
//   err_sticky          set by the first delivered non-fitting result
//   clr_err             synchronous clear of err_count/err_sticky
// -----------------------------------------------------------------------------
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [1:0]  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_field,
    output logic        out_fits,
    output logic [7:0]  err_count,
    output logic        err_sticky,
    input  logic        clr_err
);

    logic        s1_valid_reg;
    logic [31:0] s1_value_reg;
    logic [1:0]  s1_mode_reg;
    logic        s2_valid_reg;
    logic [19:0] s2_field_reg;
    logic        s2_fits_reg;
    logic [7:0]  err_count_reg;
    logic        err_sticky_reg;

    logic [7:0]  err_count_next;
    logic        err_sticky_next;
    logic        out_xfer;
    logic        in_xfer;
    logic        s2_can_load;
    logic        s2_load;
    logic [19:0] enc_field;
    logic        enc_fits;

    // Reset masks the handshakes so that no transfer is reported in the reset
    // cycle, even if S2 still holds an old result.
    assign out_xfer    = s2_valid_reg & out_ready & ~reset;
    assign s2_can_load = ~s2_valid_reg | out_xfer;
    assign s2_load     = s1_valid_reg & s2_can_load;
    assign in_ready    = ~reset & (~s1_valid_reg | s2_can_load);
    assign in_xfer     = in_valid & in_ready;

    // run_eq[k] is set when bits k+1 and k agree. A run of set bits down to
    // position p means value[31:p] is a pure sign extension.
    logic [30:15] run_eq;
    genvar gi;
    generate
        for (gi = 15; gi <= 30; gi++) begin : g_run
            assign run_eq[gi] = ~(s1_value_reg[gi+1] ^ s1_value_reg[gi]);
        end
    endgenerate

    always_comb begin
        enc_field = 20'h00000;
        enc_fits  = 1'b0;
        case (s1_mode_reg)
            2'b00: begin
                enc_fits  = (s1_value_reg[31:16] == 16'h0000);
                enc_field = {4'b0000, s1_value_reg[15:0]};
            end
            2'b01: begin
                enc_fits  = &run_eq;
                enc_field = {4'b0000, s1_value_reg[15:0]};
            end
            2'b10: begin
                enc_fits  = (s1_value_reg[1:0] == 2'b00) & (&run_eq[30:21]);
                enc_field = s1_value_reg[21:2];
            end
            default: begin
                enc_field = 20'h00000;
                enc_fits  = 1'b0;
            end
        endcase
    end

    // Clear takes priority over the increment; the count sticks at 8'hFF.
    always_comb begin
        err_count_next  = err_count_reg;
        err_sticky_next = err_sticky_reg;
        if (clr_err) begin
            err_count_next  = 8'h00;
            err_sticky_next = 1'b0;
        end else if (out_xfer && !s2_fits_reg) begin
            if (err_count_reg != 8'hFF) begin
                err_count_next = err_count_reg + 8'h01;
            end
            err_sticky_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg   <= 1'b0;
            s1_value_reg   <= 32'h0;
            s1_mode_reg    <= 2'b00;
            s2_valid_reg   <= 1'b0;
            s2_field_reg   <= 20'h00000;
            s2_fits_reg    <= 1'b0;
            err_count_reg  <= 8'h00;
            err_sticky_reg <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid_reg <= 1'b1;
                s1_value_reg <= in_value;
                s1_mode_reg  <= in_mode;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                s2_valid_reg <= 1'b1;
                s2_field_reg <= enc_field;
                s2_fits_reg  <= enc_fits;
            end else if (out_xfer) begin
                s2_valid_reg <= 1'b0;
            end

            err_count_reg  <= err_count_next;
            err_sticky_reg <= err_sticky_next;
        end
    end

    assign out_valid  = s2_valid_reg & ~reset;
    assign out_field  = s2_field_reg;
    assign out_fits   = s2_fits_reg;
    assign err_count  = err_count_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Scoreboard bench for imm_encoder. The driver pushes the reference result
// for every accepted request. A separate negedge monitor pops and compares
// each delivered result, checks that the output holds under backpressure,
// checks the round trip for fitting results, and tracks a reference error
// counter.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_field;
    logic        out_fits;
    logic [7:0]  err_count;
    logic        err_sticky;
    logic        clr_err;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_field  (out_field),
        .out_fits   (out_fits),
        .err_count  (err_count),
        .err_sticky (err_sticky),
        .clr_err    (clr_err)
    );

    typedef struct {
        logic [31:0] value;
        logic [1:0]  mode;
        logic [19:0] field;
        logic        fits;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    int    accepted = 0;
    int    delivered = 0;
    bit    rand_rdy = 0;
    bit    last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference encoding, derived from the numeric range of each mode.
    function automatic item_t model(input logic [31:0] v, input logic [1:0] m);
        item_t it;
        int    sv;
        sv       = $signed(v);
        it.value = v;
        it.mode  = m;
        case (m)
            2'd0: begin
                it.fits  = (v < 32'h10000);
                it.field = 20'(v % 32'h10000);
            end
            2'd1: begin
                it.fits  = (sv >= -32768) && (sv <= 32767);
                it.field = 20'(v % 32'h10000);
            end
            2'd2: begin
                it.fits  = (v % 4 == 0) && (sv >= -(1 << 21)) && (sv < (1 << 21));
                it.field = 20'(v / 4);
            end
            default: begin
                it.fits  = 1'b0;
                it.field = 20'h0;
            end
        endcase
        return it;
    endfunction

    // One clock cycle. The driver records an acceptance at the negedge.
    task automatic cyc();
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        last_acc = in_valid && in_ready && !reset;
        if (last_acc) begin
            q.push_back(model(in_value, in_mode));
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic [1:0] m);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_value = v;
        in_mode  = m;
        for (int i = 0; i < 100 && !done; i++) begin
            cyc();
            done = last_acc;
        end
        if (!done) chk("send_timeout", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    // Monitor: compares delivered results with the scoreboard and models the
    // error counter.
    item_t       mon_it;
    int          mcnt = 0;
    bit          msticky = 0;
    bit          held = 0;
    logic [19:0] hfield;
    logic        hfits;
    logic [31:0] rec;
    bit          fail_ev;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mcnt    = 0;
            msticky = 0;
            held    = 0;
        end else begin
            chk("err_count", 32'(err_count), 32'(mcnt));
            chk("err_sticky", 32'(err_sticky), 32'(msticky));
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_field", 32'(out_field), 32'(hfield));
                chk("hold_fits", 32'(out_fits), 32'(hfits));
            end
            fail_ev = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(q.size()), 32'd1);
                end else begin
                    mon_it = q.pop_front();
                    delivered++;
                    chk("field", 32'(out_field), 32'(mon_it.field));
                    chk("fits", 32'(out_fits), 32'(mon_it.fits));
                    if (out_fits) begin
                        case (mon_it.mode)
                            2'd0:    rec = {16'h0, out_field[15:0]};
                            2'd1:    rec = {{16{out_field[15]}}, out_field[15:0]};
                            2'd2:    rec = {{10{out_field[19]}}, out_field, 2'b00};
                            default: rec = ~mon_it.value;
                        endcase
                        chk("round_trip", rec, mon_it.value);
                    end
                    fail_ev = !mon_it.fits;
                end
            end
            if (clr_err) begin
                mcnt    = 0;
                msticky = 0;
            end else if (fail_ev) begin
                if (mcnt < 255) mcnt++;
                msticky = 1;
            end
            held   = out_valid && !out_ready;
            hfield = out_field;
            hfits  = out_fits;
        end
    end

    function automatic logic [31:0] rand_value();
        logic [31:0] edges [12];
        logic [31:0] v;
        edges = '{32'h0, 32'h0000FFFF, 32'h00010000, 32'h00007FFF, 32'h00008000,
                  32'hFFFF8000, 32'hFFFF7FFF, 32'h001FFFFC, 32'h00200000,
                  32'hFFE00000, 32'hFFDFFFFC, 32'hFFFFFFFF};
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 80000)) - 32'd40000;
            2: begin
                v = 32'($urandom_range(0, 32'h00400000)) - 32'h00200000;
                if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
            end
            default: v = edges[$urandom_range(0, 11)];
        endcase
        return v;
    endfunction

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 32'h0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        clr_err   = 1'b0;

        // Reset behaviour.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_field", 32'(out_field), 32'd0);
        chk("post_rst_fits", 32'(out_fits), 32'd0);
        @(posedge clk);
        #1;

        // Latency of two cycles, sign-extended minimum.
        out_ready = 1'b1;
        send(32'hFFFF8000, 2'd1);
        @(negedge clk);
        chk("lat_early_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_field", 32'(out_field), 32'h08000);
        chk("lat_fits", 32'(out_fits), 32'd1);
        @(posedge clk);
        #1;

        // Branch mode: overflow, then a negative in-range offset.
        send(32'h00200000, 2'd2);
        send(32'hFFE00004, 2'd2);
        repeat (4) cyc();
        chk("br_err_count", 32'(err_count), 32'd1);
        chk("br_err_sticky", 32'(err_sticky), 32'd1);

        // Backpressure: only two requests fit while the output stalls.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_value  = 32'd1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (last_acc) begin
                n++;
                in_value = 32'(n + 1);
            end
        end
        chk("bp_accepted", 32'(n), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'd3, 2'd0);
        repeat (5) cyc();

        // Error counter saturation, then a clear on a failing delivery.
        for (int i = 0; i < 300; i++) send($urandom, 2'd3);
        repeat (4) cyc();
        chk("sat_err_count", 32'(err_count), 32'hFF);
        chk("sat_err_sticky", 32'(err_sticky), 32'd1);
        send(32'h0, 2'd3);
        cyc();
        clr_err = 1'b1;
        @(negedge clk);
        chk("clr_coincident_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_err_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1;

        // Reset with both stages full.
        send(32'h0, 2'd3);
        repeat (3) cyc();
        out_ready = 1'b0;
        send(32'd5, 2'd0);
        send(32'd6, 2'd0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_out_valid", 32'(out_valid), 32'd0);
        chk("after_rst_err_count", 32'(err_count), 32'd0);
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        accepted  = 0;
        delivered = 0;
        repeat (3) cyc();

        // Random stream with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) cyc();
            else send(rand_value(), 2'($urandom_range(0, 3)));
        end

        // Drain the pipeline.
        rand_rdy  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) cyc();
        repeat (2) cyc();
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("delivered_count", 32'(delivered), 32'(accepted));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
